soc_system_pwm_gen: RTL and testbench

Hardware PWM generator that consumes the 8-bit duty word driven by the HPS-writable PWM PIO and turns it into a glitch-free pulse train on an FPGA pin. Duty and clock-divider updates take effect only at PWM period boundaries, so software writes never produce runt pulses. The block sits in the FPGA fabric between the PIO `out_port` and the board-level PWM pin, in the same clock domain as the Avalon fabric clock.

---
 rtl/soc_system_pwm_gen.sv | 69 ++++++
 tb/tb_soc_system_pwm_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pwm_gen.sv
// soc_system_pwm_gen: 8-bit PWM with prescaler; duty/divider reload only at period boundaries.
// Define PWM_RAMP_EN for soft start (duty_q steps by 1 per period toward duty_in).
module soc_system_pwm_gen #(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 195
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       duty_in,
    input  logic [DIV_W-1:0] div_in,
    output logic             pwm_out,
    output logic             period_tick,
    output logic [7:0]       duty_active
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d, div_q, div_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d, duty_q, duty_d, duty_next, duty_idle;
    logic             pwm_out_q, pwm_out_d, period_tick_q, period_tick_d;
    logic             run, pre_tick, boundary, idle_load;

    always_comb begin
        run       = state_q == RUN && enable;
        pre_tick  = pre_cnt_q == div_q;
        boundary  = state_q == RUN && pre_tick && pwm_cnt_q == 8'hff;
        idle_load = state_q == IDLE || !enable;
`ifdef PWM_RAMP_EN
        duty_next = duty_q < duty_in ? duty_q + 8'd1 : duty_q > duty_in ? duty_q - 8'd1 : duty_q;
        duty_idle = 8'd0;
`else
        duty_next = duty_in;
        duty_idle = duty_in;
`endif
        state_d       = enable ? RUN : IDLE;
        pre_cnt_d     = run && !pre_tick ? pre_cnt_q + 1'b1 : '0;
        pwm_cnt_d     = !run ? 8'd0 : pre_tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        pwm_out_d     = run && pwm_cnt_q < duty_q;
        period_tick_d = enable && (state_q == IDLE || boundary);
        div_d         = idle_load || boundary ? div_in : div_q;
        // a boundary coinciding with disable still performs its load
        duty_d        = boundary ? duty_next : idle_load ? duty_idle : duty_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= 8'd0;
            duty_q        <= 8'd0;
            div_q         <= DIV_W'(DIV_DEFAULT);
            pwm_out_q     <= 1'b0;
            period_tick_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            duty_q        <= duty_d;
            div_q         <= div_d;
            pwm_out_q     <= pwm_out_d;
            period_tick_q <= period_tick_d;
        end
    end

    assign pwm_out     = pwm_out_q;
    assign period_tick = period_tick_q;
    assign duty_active = duty_q;
endmodule

// File: tb/tb_soc_system_pwm_gen.sv
// tb_soc_system_pwm_gen: period-position model plus directed duty/divider/ramp/reset scenarios.
module tb_soc_system_pwm_gen;
    localparam int DEF = 195;

    logic        clk = 0, reset = 1, enable = 0;
    logic [7:0]  duty_in = 0;
    logic [15:0] div_in = 0;
    logic        pwm_out, period_tick;
    logic [7:0]  duty_active;
    int checks = 0, errors = 0;

    soc_system_pwm_gen dut (
        .clk(clk), .reset(reset), .enable(enable), .duty_in(duty_in), .div_in(div_in),
        .pwm_out(pwm_out), .period_tick(period_tick), .duty_active(duty_active)
    );

    always #5 clk = ~clk;

    // model: position k within the current period, applied duty d and divider dv
    bit m_run = 0;
    int m_k = 0, m_d = 0, m_dv = DEF;

    function automatic int next_duty(input int d, input int req);
`ifdef PWM_RAMP_EN
        return d < req ? d + 1 : d > req ? d - 1 : d;
`else
        return req;
`endif
    endfunction

    function automatic int idle_duty(input int req);
`ifdef PWM_RAMP_EN
        return 0;
`else
        return req;
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 0; m_k = 0; m_d = 0; m_dv = DEF;
        end else if (!enable) begin
            m_d   = (m_run && m_k == 256 * (m_dv + 1) - 1) ? next_duty(m_d, duty_in) : idle_duty(duty_in);
            m_run = 0; m_k = 0; m_dv = div_in;
        end else if (!m_run) begin
            m_run = 1; m_k = 0; m_dv = div_in; m_d = idle_duty(duty_in);
        end else if (m_k == 256 * (m_dv + 1) - 1) begin
            m_k = 0; m_d = next_duty(m_d, duty_in); m_dv = div_in;
        end else
            m_k++;
    end

    always @(negedge clk) begin
        logic e_pwm, e_tick;
        e_pwm  = m_run && m_k >= 1 && m_k <= m_d * (m_dv + 1);
        e_tick = m_run && m_k == 0;
        checks++;
        if (pwm_out !== e_pwm || period_tick !== e_tick || duty_active !== 8'(m_d)) begin
            errors++;
            $display("FAIL model t=%0t pwm=%b/%b tick=%b/%b duty=%0d/%0d", $time,
                     pwm_out, e_pwm, period_tick, e_tick, duty_active, m_d);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        bit found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (period_tick) begin found = 1; break; end
        end
        if (!found) chk("tick_timeout", 0, 1);
    endtask

    // counts high clocks over one period starting at its period_tick
    task automatic measure(input int len, output int hi, output int da);
        wait_tick();
        da = duty_active;
        hi = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            hi += int'(pwm_out);
        end
    endtask

    int hi, da, sum;
    int ramp_exp[10] = '{0, 1, 2, 3, 4, 5, 5, 4, 3, 3};

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_pwm", pwm_out, 0);
        chk("reset_tick", period_tick, 0);
        chk("reset_duty", duty_active, 0);
        reset = 0;
        duty_in = 5;
        repeat (3) @(negedge clk);
        enable = 1;
`ifdef PWM_RAMP_EN
        for (int p = 0; p < 10; p++) begin
            if (p == 7) duty_in = 3;
            measure(256, hi, da);
            chk($sformatf("ramp_p%0d", p), hi, ramp_exp[p]);
        end
`else
        measure(256, hi, da);
        chk("first_period_hi", hi, 5);
`endif
        duty_in = 64;
        measure(256, hi, da);
        measure(256, hi, da);
`ifndef PWM_RAMP_EN
        chk("basic_hi", hi, 64);
        chk("basic_duty", da, 64);
`endif
        wait_tick();
        hi = int'(pwm_out);
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            if (i == 100) duty_in = 192;
            hi += int'(pwm_out);
        end
        measure(256, hi, da);
`ifndef PWM_RAMP_EN
        chk("midupd_next_hi", hi, 192);
        chk("midupd_duty", da, 192);
`endif
        duty_in = 0;
        sum = 0;
        for (int p = 0; p < 3; p++) begin
            measure(256, hi, da);
            sum += hi;
        end
`ifndef PWM_RAMP_EN
        chk("duty0_hi", sum, 0);
`endif
        duty_in = 255;
        measure(256, hi, da);
`ifndef PWM_RAMP_EN
        chk("duty255_hi", hi, 255);
`endif
        div_in = 3;
        duty_in = 10;
        measure(1024, hi, da);
`ifndef PWM_RAMP_EN
        chk("div3_hi", hi, 40);
`endif
        wait_tick();
        hi = int'(pwm_out);
        for (int i = 1; i < 1024; i++) begin
            @(negedge clk);
            if (i == 300) div_in = 0;
            hi += int'(pwm_out);
        end
`ifndef PWM_RAMP_EN
        chk("div_mid_hi", hi, 40);
`endif
        measure(256, hi, da);
`ifndef PWM_RAMP_EN
        chk("div0_hi", hi, 10);
`endif
        wait_tick();
        repeat (5) @(negedge clk);
        enable = 0;
        @(negedge clk);
        chk("disable_pwm", pwm_out, 0);
        chk("disable_tick", period_tick, 0);
        duty_in = 128;
        div_in = 0;
        repeat (2) @(negedge clk);
        enable = 1;
        wait_tick();
        repeat (50) @(negedge clk);
`ifndef PWM_RAMP_EN
        chk("pre_reset_pwm", pwm_out, 1);
`endif
        #2 reset = 1;
        #1;
        chk("async_reset_pwm", pwm_out, 0);
        chk("async_reset_duty", duty_active, 0);
        chk("async_reset_tick", period_tick, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("post_reset_tick", period_tick, 1);
        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
